// File: rtl/pong_core.sv
// pong_core: two-player Pong engine with one ball, two paddles, scoring and a
// match FSM (IDLE -> SERVE -> PLAY -> POINT -> SERVE ... -> OVER).
// The VGA pixel path asks whether cell (i_col,i_row) is lit. The answer
// appears on o_draw one clock later.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_start               start/restart request (level), honoured in IDLE/OVER
//   i_p1_up, i_p1_down    left paddle buttons (pre-debounced)
//   i_p2_up, i_p2_down    right paddle buttons (pre-debounced)
//   i_row, i_col          cell being scanned
//   o_draw                cell lit (ball or paddle), registered
//   o_ball_direction      [0]=1 moving right, [1]=1 moving down
//   o_p1_score/o_p2_score current scores
//   o_state               IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
//
// Optional feature: define PONG_AI_P2_EN to let the right paddle track the
// ball row on its own. When this is defined, i_p2_up and i_p2_down are ignored.
module pong_core #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int COORD_W       = 6,
  parameter int PADDLE_HEIGHT = 6,
  parameter int BALL_DIV      = 1250000,
  parameter int PADDLE_DIV    = 625000,
  parameter int SERVE_TICKS   = 40,
  parameter int WIN_SCORE     = 9,
  parameter int SCORE_W       = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_p1_up,
  input  logic               i_p1_down,
  input  logic               i_p2_up,
  input  logic               i_p2_down,
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  output logic               o_draw,
  output logic [1:0]         o_ball_direction,
  output logic [SCORE_W-1:0] o_p1_score,
  output logic [SCORE_W-1:0] o_p2_score,
  output logic [2:0]         o_state
);

  localparam int BCNT_W = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int PCNT_W = (PADDLE_DIV > 1) ? $clog2(PADDLE_DIV) : 1;
  localparam int SCNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int CW1    = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_CENTRE    = COORD_W'(GAME_WIDTH / 2);
  localparam logic [COORD_W-1:0] Y_CENTRE    = COORD_W'(GAME_HEIGHT / 2);
  localparam logic [COORD_W-1:0] PAD_TOP_RST = COORD_W'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
  localparam logic [COORD_W-1:0] PAD_TOP_MAX = COORD_W'(GAME_HEIGHT - PADDLE_HEIGHT);
  localparam logic [COORD_W-1:0] X_MAX       = COORD_W'(GAME_WIDTH - 1);
  localparam logic [COORD_W-1:0] X_P2_GATE   = COORD_W'(GAME_WIDTH - 2);
  localparam logic [COORD_W-1:0] X_P2_BOUNCE = COORD_W'(GAME_WIDTH - 3);
  localparam logic [COORD_W-1:0] X_P1_GATE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] X_P1_BOUNCE = COORD_W'(2);
  localparam logic [COORD_W-1:0] Y_MAX       = COORD_W'(GAME_HEIGHT - 1);
  localparam logic [COORD_W-1:0] COORD_ZERO  = {COORD_W{1'b0}};
  localparam logic [COORD_W-1:0] COORD_ONE   = COORD_W'(1);
  localparam logic [CW1-1:0]     PAD_LEN     = CW1'(PADDLE_HEIGHT);
  localparam logic [CW1-1:0]     X_LIMIT     = CW1'(GAME_WIDTH);
  localparam logic [CW1-1:0]     Y_LIMIT     = CW1'(GAME_HEIGHT);
  localparam logic [BCNT_W-1:0]  BALL_LAST   = BCNT_W'(BALL_DIV - 1);
  localparam logic [PCNT_W-1:0]  PAD_LAST    = PCNT_W'(PADDLE_DIV - 1);
  localparam logic [SCNT_W-1:0]  SERVE_LAST  = SCNT_W'(SERVE_TICKS - 1);
  localparam logic [SCORE_W-1:0] SCORE_WIN   = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ZERO  = {SCORE_W{1'b0}};
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  // True when row y lies inside the paddle whose top row is top.
  // The comparison is done one bit wider so that top+length cannot wrap.
  function automatic logic in_span(input logic [COORD_W-1:0] top,
                                   input logic [COORD_W-1:0] y);
    logic [CW1-1:0] y_e;
    logic [CW1-1:0] top_e;
    y_e   = {1'b0, y};
    top_e = {1'b0, top};
    return (y_e >= top_e) && (y_e < (top_e + PAD_LEN));
  endfunction

  // Moves a paddle by one cell and clamps it to the playfield.
  // Pressing both buttons, or neither, holds the paddle.
  function automatic logic [COORD_W-1:0] paddle_step(input logic [COORD_W-1:0] top,
                                                     input logic up,
                                                     input logic down);
    logic [COORD_W-1:0] nxt;
    nxt = top;
    if (up && !down && (top != COORD_ZERO)) begin
      nxt = top - COORD_ONE;
    end else if (down && !up && (top < PAD_TOP_MAX)) begin
      nxt = top + COORD_ONE;
    end else begin
      nxt = top;
    end
    return nxt;
  endfunction

  state_e             state_q, state_d;
  logic [BCNT_W-1:0]  ball_cnt_q, ball_cnt_d;
  logic [PCNT_W-1:0]  pad_cnt_q, pad_cnt_d;
  logic [SCNT_W-1:0]  serve_cnt_q, serve_cnt_d;
  logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d;
  logic [1:0]         dir_q, dir_d;
  logic [COORD_W-1:0] p1_top_q, p1_top_d, p2_top_q, p2_top_d;
  logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
  logic               p1_point_q, p1_point_d;
  logic               draw_q, draw_d;

  logic               ball_tick_s, pad_tick_s;
  logic               p2_up_s, p2_down_s;
  logic               dir_x_s, dir_y_s;
  logic [COORD_W-1:0] nx_s, ny_s;
  logic [SCORE_W-1:0] p1_inc_s, p2_inc_s;

  assign ball_tick_s = (ball_cnt_q == BALL_LAST);
  assign pad_tick_s  = (pad_cnt_q == PAD_LAST);
  assign p1_inc_s    = p1_score_q + SCORE_ONE;
  assign p2_inc_s    = p2_score_q + SCORE_ONE;

`ifdef PONG_AI_P2_EN
  logic [CW1-1:0] p2_centre_s;
  assign p2_centre_s = {1'b0, p2_top_q} + CW1'(PADDLE_HEIGHT / 2);

  // Automatic right paddle: move the paddle centre one cell toward the ball row.
  always_comb begin
    p2_up_s   = 1'b0;
    p2_down_s = 1'b0;
    if (p2_centre_s < {1'b0, by_q}) begin
      p2_down_s = 1'b1;
    end else if (p2_centre_s > {1'b0, by_q}) begin
      p2_up_s = 1'b1;
    end else begin
      p2_up_s   = 1'b0;
      p2_down_s = 1'b0;
    end
  end
`else
  // Manual right paddle, driven directly by the buttons.
  always_comb begin
    p2_up_s   = i_p2_up;
    p2_down_s = i_p2_down;
  end
`endif

  // Next state for the tick counters, paddles, ball and match FSM.
  always_comb begin
    state_d     = state_q;
    ball_cnt_d  = ball_tick_s ? {BCNT_W{1'b0}} : (ball_cnt_q + BCNT_W'(1));
    pad_cnt_d   = pad_tick_s ? {PCNT_W{1'b0}} : (pad_cnt_q + PCNT_W'(1));
    serve_cnt_d = serve_cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dir_d       = dir_q;
    p1_top_d    = p1_top_q;
    p2_top_d    = p2_top_q;
    p1_score_d  = p1_score_q;
    p2_score_d  = p2_score_q;
    p1_point_d  = p1_point_q;
    dir_x_s     = dir_q[0];
    dir_y_s     = dir_q[1];
    nx_s        = bx_q;
    ny_s        = by_q;

    // Paddles freeze once the match is over.
    if (pad_tick_s && (state_q != ST_OVER)) begin
      p1_top_d = paddle_step(p1_top_q, i_p1_up, i_p1_down);
      p2_top_d = paddle_step(p2_top_q, p2_up_s, p2_down_s);
    end else begin
      p1_top_d = p1_top_q;
      p2_top_d = p2_top_q;
    end

    case (state_q)
      ST_IDLE: begin
        bx_d = X_CENTRE;
        by_d = Y_CENTRE;
        if (i_start) begin
          state_d     = ST_SERVE;
          p1_score_d  = SCORE_ZERO;
          p2_score_d  = SCORE_ZERO;
          serve_cnt_d = {SCNT_W{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        bx_d = X_CENTRE;
        by_d = Y_CENTRE;
        if (ball_tick_s) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d     = ST_PLAY;
            serve_cnt_d = {SCNT_W{1'b0}};
          end else begin
            serve_cnt_d = serve_cnt_q + SCNT_W'(1);
          end
        end else begin
          serve_cnt_d = serve_cnt_q;
        end
      end
      ST_PLAY: begin
        if (ball_tick_s) begin
          // A wall bounce flips the vertical direction and steps away on the same tick.
          if (((by_q == COORD_ZERO) && !dir_q[1]) || ((by_q == Y_MAX) && dir_q[1])) begin
            dir_y_s = ~dir_q[1];
          end else begin
            dir_y_s = dir_q[1];
          end
          ny_s = dir_y_s ? (by_q + COORD_ONE) : (by_q - COORD_ONE);
          // The paddle check uses the ball row before this step and the
          // paddle position before its own move on this clock.
          if (!dir_q[0] && (bx_q == X_P1_GATE)) begin
            if (in_span(p1_top_q, by_q)) begin
              dir_x_s = 1'b1;
              nx_s    = X_P1_BOUNCE;
            end else begin
              nx_s       = COORD_ZERO;
              state_d    = ST_POINT;
              p1_point_d = 1'b0;
            end
          end else if (dir_q[0] && (bx_q == X_P2_GATE)) begin
            if (in_span(p2_top_q, by_q)) begin
              dir_x_s = 1'b0;
              nx_s    = X_P2_BOUNCE;
            end else begin
              nx_s       = X_MAX;
              state_d    = ST_POINT;
              p1_point_d = 1'b1;
            end
          end else begin
            nx_s = dir_q[0] ? (bx_q + COORD_ONE) : (bx_q - COORD_ONE);
          end
          bx_d  = nx_s;
          by_d  = ny_s;
          dir_d = {dir_y_s, dir_x_s};
        end else begin
          bx_d = bx_q;
        end
      end
      ST_POINT: begin
        // The next serve heads toward the player who lost the point.
        if (p1_point_q) begin
          p1_score_d = p1_inc_s;
          if (p1_inc_s == SCORE_WIN) begin
            state_d = ST_OVER;
          end else begin
            state_d     = ST_SERVE;
            dir_d[0]    = 1'b1;
            bx_d        = X_CENTRE;
            by_d        = Y_CENTRE;
            serve_cnt_d = {SCNT_W{1'b0}};
          end
        end else begin
          p2_score_d = p2_inc_s;
          if (p2_inc_s == SCORE_WIN) begin
            state_d = ST_OVER;
          end else begin
            state_d     = ST_SERVE;
            dir_d[0]    = 1'b0;
            bx_d        = X_CENTRE;
            by_d        = Y_CENTRE;
            serve_cnt_d = {SCNT_W{1'b0}};
          end
        end
      end
      ST_OVER: begin
        if (i_start) begin
          state_d     = ST_SERVE;
          p1_score_d  = SCORE_ZERO;
          p2_score_d  = SCORE_ZERO;
          bx_d        = X_CENTRE;
          by_d        = Y_CENTRE;
          serve_cnt_d = {SCNT_W{1'b0}};
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pixel query: ball or either paddle at the scanned cell. The ball is hidden in IDLE.
  always_comb begin
    draw_d = 1'b0;
    if (({1'b0, i_col} < X_LIMIT) && ({1'b0, i_row} < Y_LIMIT)) begin
      draw_d = ((state_q != ST_IDLE) && (i_col == bx_q) && (i_row == by_q)) ||
               ((i_col == COORD_ZERO) && in_span(p1_top_q, i_row)) ||
               ((i_col == X_MAX) && in_span(p2_top_q, i_row));
    end else begin
      draw_d = 1'b0;
    end
  end

  // State register for the FSM and datapath.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ball_cnt_q  <= {BCNT_W{1'b0}};
      pad_cnt_q   <= {PCNT_W{1'b0}};
      serve_cnt_q <= {SCNT_W{1'b0}};
      bx_q        <= X_CENTRE;
      by_q        <= Y_CENTRE;
      dir_q       <= 2'b11;
      p1_top_q    <= PAD_TOP_RST;
      p2_top_q    <= PAD_TOP_RST;
      p1_score_q  <= SCORE_ZERO;
      p2_score_q  <= SCORE_ZERO;
      p1_point_q  <= 1'b0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_cnt_q  <= ball_cnt_d;
      pad_cnt_q   <= pad_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dir_q       <= dir_d;
      p1_top_q    <= p1_top_d;
      p2_top_q    <= p2_top_d;
      p1_score_q  <= p1_score_d;
      p2_score_q  <= p2_score_d;
      p1_point_q  <= p1_point_d;
      draw_q      <= draw_d;
    end
  end

  assign o_draw           = draw_q;
  assign o_ball_direction = dir_q;
  assign o_p1_score       = p1_score_q;
  assign o_p2_score       = p2_score_q;
  assign o_state          = state_q;

endmodule

// File: tb/tb_pong_core.sv
// tb_pong_core: directed self-checking bench for pong_core on a 16x12 field
// (paddle 4, both dividers 2, serve 2 ticks, match won at 3 points).
// Every expected value below is hand-traced from the game rules.
module tb_pong_core;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int CW = 6;
  localparam int SW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_p1_up = 1'b0, i_p1_down = 1'b0;
  logic          i_p2_up = 1'b0, i_p2_down = 1'b0;
  logic [CW-1:0] i_row = '0, i_col = '0;
  logic          o_draw;
  logic [1:0]    o_ball_direction;
  logic [SW-1:0] o_p1_score, o_p2_score;
  logic [2:0]    o_state;

  int n_cmp = 0;
  int n_err = 0;

  pong_core #(
    .GAME_WIDTH(GW), .GAME_HEIGHT(GH), .COORD_W(CW), .PADDLE_HEIGHT(4),
    .BALL_DIV(2), .PADDLE_DIV(2), .SERVE_TICKS(2), .WIN_SCORE(3), .SCORE_W(SW)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_p1_up(i_p1_up), .i_p1_down(i_p1_down),
    .i_p2_up(i_p2_up), .i_p2_down(i_p2_down),
    .i_row(i_row), .i_col(i_col),
    .o_draw(o_draw), .o_ball_direction(o_ball_direction),
    .o_p1_score(o_p1_score), .o_p2_score(o_p2_score), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Present a cell at a falling edge; o_draw at the next falling edge
  // reflects the game state that was in place when the cell was presented.
  task automatic probe(input int c, input int r);
    i_col = CW'(c);
    i_row = CW'(r);
    @(negedge i_clk);
  endtask

  task automatic test_reset();
    int  cols [10] = '{0, 0, 0, 0, 15, 15, 8, 5, 16, 0};
    int  rows [10] = '{4, 7, 3, 8, 4, 7, 6, 5, 4, 12};
    bit  expd [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge i_clk);
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL reset_draw: got %b expected 0", o_draw); end
    i_rst = 1'b0;
    n_cmp++; if (o_ball_direction !== 2'b11) begin n_err++; $display("FAIL reset_dir: got %b expected 11", o_ball_direction); end
    n_cmp++; if (o_p1_score !== 4'd0 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", o_p1_score, o_p2_score); end
    for (int k = 0; k < 10; k++) begin
      probe(cols[k], rows[k]);
      n_cmp++;
      if (o_draw !== expd[k]) begin
        n_err++;
        $display("FAIL idle_draw(%0d,%0d): got %b expected %b", cols[k], rows[k], o_draw, expd[k]);
      end
    end
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL idle_hold: got %0d expected 0", o_state); end
  endtask

  // Start, P1 paddle driven to its floor (top 8), P2 to its ceiling (top 0).
  task automatic test_serve_play();
    int n;
    i_start = 1'b1; i_p1_down = 1'b1; i_p2_up = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n_cmp++; if (o_state !== 3'd1) begin n_err++; $display("FAIL serve_enter: got %0d expected 1", o_state); end
    n = 0;
    while (o_state !== 3'd2 && n < 20) begin @(negedge i_clk); n++; end
    n_cmp++; if (n < 3 || n > 4) begin n_err++; $display("FAIL serve_len: got %0d clocks expected 3..4", n); end
    probe(8, 6);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL play_start_ball: got %b expected 1", o_draw); end
    probe(9, 7);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL play_no_early_step: got %b expected 0", o_draw); end
    probe(9, 7);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL play_first_step: got %b expected 1", o_draw); end
    n_cmp++; if (o_ball_direction !== 2'b11) begin n_err++; $display("FAIL play_dir: got %b expected 11", o_ball_direction); end
  endtask

  // Ball (13,11) moving down flips to up and lands on (14,10).
  task automatic test_wall_bounce();
    repeat (7) @(negedge i_clk);
    probe(13, 11);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL wall_pre_pos: got %b expected 1", o_draw); end
    n_cmp++; if (o_ball_direction !== 2'b11) begin n_err++; $display("FAIL wall_pre_dir: got %b expected 11", o_ball_direction); end
    probe(14, 10);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL wall_not_yet: got %b expected 0", o_draw); end
    n_cmp++; if (o_ball_direction !== 2'b01) begin n_err++; $display("FAIL wall_dir_flip: got %b expected 01", o_ball_direction); end
    probe(14, 10);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL wall_post_pos: got %b expected 1", o_draw); end
  endtask

  // P2 paddle at top 0 misses the ball at row 10: P1 scores, serve heads right.
  task automatic test_point();
    @(negedge i_clk);
    n_cmp++; if (o_state !== 3'd3) begin n_err++; $display("FAIL point_state: got %0d expected 3", o_state); end
    probe(15, 9);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL point_ball_pos: got %b expected 1", o_draw); end
    n_cmp++; if (o_state !== 3'd1) begin n_err++; $display("FAIL point_to_serve: got %0d expected 1", o_state); end
    n_cmp++; if (o_p1_score !== 4'd1 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL point_score: got %0d/%0d expected 1/0", o_p1_score, o_p2_score); end
    n_cmp++; if (o_ball_direction !== 2'b01) begin n_err++; $display("FAIL point_dir: got %b expected 01", o_ball_direction); end
    probe(15, 0);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL p2_top0: got %b expected 1", o_draw); end
    probe(15, 4);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL p2_left_row4: got %b expected 0", o_draw); end
    probe(8, 6);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL serve_centre: got %b expected 1", o_draw); end
  endtask

  // Rally 2 bounces off both paddles before P1 scores; rally 3 ends the match.
  task automatic test_match_over();
    int n;
    n = 0;
    while (o_p1_score !== 4'd2 && n < 300) begin @(negedge i_clk); n++; end
    n_cmp++; if (o_p1_score !== 4'd2 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL rally2_score: got %0d/%0d expected 2/0", o_p1_score, o_p2_score); end
    n_cmp++; if (o_state !== 3'd1) begin n_err++; $display("FAIL rally2_serve: got %0d expected 1", o_state); end
    n_cmp++; if (o_ball_direction !== 2'b11) begin n_err++; $display("FAIL rally2_dir: got %b expected 11", o_ball_direction); end
    n = 0;
    while (o_state !== 3'd4 && n < 300) begin @(negedge i_clk); n++; end
    n_cmp++; if (o_state !== 3'd4) begin n_err++; $display("FAIL over_state: got %0d expected 4", o_state); end
    n_cmp++; if (o_p1_score !== 4'd3 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL over_score: got %0d/%0d expected 3/0", o_p1_score, o_p2_score); end
    repeat (6) @(negedge i_clk);
    probe(15, 9);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL over_ball_static: got %b expected 1", o_draw); end
    n_cmp++; if (o_state !== 3'd4 || o_p1_score !== 4'd3) begin n_err++; $display("FAIL over_hold: got state %0d score %0d expected 4/3", o_state, o_p1_score); end
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    n_cmp++; if (o_state !== 3'd1) begin n_err++; $display("FAIL restart_state: got %0d expected 1", o_state); end
    n_cmp++; if (o_p1_score !== 4'd0 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL restart_scores: got %0d/%0d expected 0/0", o_p1_score, o_p2_score); end
    probe(8, 6);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL restart_centre: got %b expected 1", o_draw); end
  endtask

  // Both P1 buttons held: paddle stays at top 8. Then an async reset mid-play.
  task automatic test_hold_and_reset();
    int n;
    i_p1_up = 1'b1;
    repeat (20) @(negedge i_clk);
    probe(0, 8);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL hold_row8: got %b expected 1", o_draw); end
    probe(0, 11);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL hold_row11: got %b expected 1", o_draw); end
    probe(0, 7);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL hold_row7: got %b expected 0", o_draw); end
    n = 0;
    while (o_p1_score !== 4'd1 && n < 300) begin @(negedge i_clk); n++; end
    n_cmp++; if (o_p1_score !== 4'd1 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL hold_rally_score: got %0d/%0d expected 1/0", o_p1_score, o_p2_score); end
    n = 0;
    while (o_state !== 3'd2 && n < 20) begin @(negedge i_clk); n++; end
    n_cmp++; if (o_state !== 3'd2) begin n_err++; $display("FAIL hold_replay: got %0d expected 2", o_state); end
    repeat (3) @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL async_rst_state: got %0d expected 0", o_state); end
    n_cmp++; if (o_p1_score !== 4'd0 || o_p2_score !== 4'd0) begin n_err++; $display("FAIL async_rst_scores: got %0d/%0d expected 0/0", o_p1_score, o_p2_score); end
    n_cmp++; if (o_ball_direction !== 2'b11 || o_draw !== 1'b0) begin n_err++; $display("FAIL async_rst_dir_draw: got %b/%b expected 11/0", o_ball_direction, o_draw); end
    i_p1_up = 1'b0; i_p1_down = 1'b0; i_p2_up = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    probe(0, 4);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL rst_p1_top: got %b expected 1", o_draw); end
    probe(0, 8);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL rst_p1_row8: got %b expected 0", o_draw); end
    probe(15, 4);
    n_cmp++; if (o_draw !== 1'b1) begin n_err++; $display("FAIL rst_p2_top: got %b expected 1", o_draw); end
    probe(15, 0);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL rst_p2_row0: got %b expected 0", o_draw); end
    probe(8, 6);
    n_cmp++; if (o_draw !== 1'b0) begin n_err++; $display("FAIL rst_ball_hidden: got %b expected 0", o_draw); end
    n_cmp++; if (o_state !== 3'd0) begin n_err++; $display("FAIL rst_idle: got %0d expected 0", o_state); end
  endtask

  initial begin
    test_reset();
    test_serve_play();
    test_wall_bounce();
    test_point();
    test_match_over();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
